vector_mem_stage: RTL and testbench

VECTOR_MEM_STAGE -- requirements
Module: vector_mem_stage

---
 rtl/vector_mem_stage.sv | 167 ++++++++++++++++
 tb/tb_vector_mem_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_stage.sv
// Memory stage of the vector pipeline: passes non-memory ops straight to write-back and
// sequences scalar (1 beat) or vector (4 beat) loads/stores over a 32-bit memory port.
module vector_mem_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         rmem,
   input  logic         wmem,
   input  logic         wreg,
   input  logic         VF,
   input  logic [3:0]   R_V_dest,
   input  logic [127:0] alu_res,
   input  logic [127:0] store_data,
   output logic         stall,
   output logic         mem_req,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   input  logic         mem_ack,
   input  logic [31:0]  mem_rdata,
   output logic         wb_wreg,
   output logic         wb_VF,
   output logic [3:0]   wb_dest,
   output logic [127:0] wb_data
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]   state_reg, state_next;
   logic [1:0]   beat_reg, beat_next;
   logic [31:0]  base_reg;
   logic [127:0] sdata_reg;
   logic [127:0] alu_reg;
   logic         vf_reg;
   logic         wreg_reg;
   logic         store_reg;
   logic [3:0]   dest_reg;
   logic [31:0]  lane_reg [4];
   logic [31:0]  sdata_lane [4];

   logic         mem_op;
   logic         last_beat;
   logic         final_ack;
   logic [127:0] load_data;

   assign mem_op    = rmem | wmem;
   assign last_beat = vf_reg ? (beat_reg == 2'd3) : (beat_reg == 2'd0);
   assign final_ack = (state_reg == BUSY) && mem_ack && last_beat;

   // The last load lane is taken straight from the bus on the final ack edge.
   assign load_data = vf_reg ? {mem_rdata, lane_reg[2], lane_reg[1], lane_reg[0]}
                             : {96'b0, mem_rdata};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE_IDX = gi;

         assign sdata_lane[gi] = sdata_reg[32*gi +: 32];

         always_ff @(posedge clk) begin
            if (rst) begin
               lane_reg[gi] <= 32'b0;
            end else if ((state_reg == BUSY) && mem_ack && !store_reg &&
                         (beat_reg == LANE_IDX)) begin
               lane_reg[gi] <= mem_rdata;
            end
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      case (state_reg)
         IDLE: begin
            if (mem_op) begin
               state_next = BUSY;
               beat_next  = 2'd0;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               if (last_beat) begin
                  state_next = IDLE;
                  beat_next  = 2'd0;
               end else begin
                  beat_next = beat_reg + 2'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            beat_next  = 2'd0;
         end
      endcase
   end

   // Stall drops in the final-ack cycle so upstream advances on the same edge as write-back.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         stall = ((state_reg == IDLE) && mem_op) || ((state_reg == BUSY) && !final_ack);
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'b0;
      mem_wdata = 32'b0;
      if (state_reg == BUSY) begin
         mem_req   = 1'b1;
         mem_we    = store_reg;
         mem_addr  = base_reg + {28'b0, beat_reg, 2'b00};
         mem_wdata = sdata_lane[beat_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         beat_reg  <= 2'd0;
         base_reg  <= 32'b0;
         sdata_reg <= 128'b0;
         alu_reg   <= 128'b0;
         vf_reg    <= 1'b0;
         wreg_reg  <= 1'b0;
         store_reg <= 1'b0;
         dest_reg  <= 4'b0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         if ((state_reg == IDLE) && mem_op) begin
            base_reg  <= {alu_res[31:2], 2'b00};
            sdata_reg <= store_data;
            alu_reg   <= alu_res;
            vf_reg    <= VF;
            wreg_reg  <= wreg;
            dest_reg  <= R_V_dest;
            // A simultaneous load request wins over the store.
            store_reg <= wmem & ~rmem;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_wreg <= 1'b0;
         wb_VF   <= 1'b0;
         wb_dest <= 4'b0;
         wb_data <= 128'b0;
      end else if ((state_reg == IDLE) && !mem_op) begin
         wb_wreg <= wreg;
         wb_VF   <= VF;
         wb_dest <= R_V_dest;
         wb_data <= alu_res;
      end else if (final_ack) begin
         wb_wreg <= wreg_reg;
         wb_VF   <= vf_reg;
         wb_dest <= dest_reg;
         wb_data <= store_reg ? alu_reg : load_data;
      end else begin
         wb_wreg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vector_mem_stage.sv
// Randomised transaction-level bench for vector_mem_stage with a memory responder and
// a reference model of write-back results and memory beats.
module tb_vector_mem_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         rmem, wmem, wreg, VF;
   logic [3:0]   R_V_dest;
   logic [127:0] alu_res, store_data;
   logic         stall, mem_req, mem_we;
   logic [31:0]  mem_addr, mem_wdata;
   logic         mem_ack;
   logic [31:0]  mem_rdata;
   logic         wb_wreg, wb_VF;
   logic [3:0]   wb_dest;
   logic [127:0] wb_data;

   int passed = 0;
   int total  = 0;

   // Expected held write-back values
   logic         m_vf;
   logic [3:0]   m_dest;
   logic [127:0] m_data;

   always #5 clk = ~clk;

   vector_mem_stage dut (
      .clk(clk), .rst(rst), .rmem(rmem), .wmem(wmem), .wreg(wreg), .VF(VF),
      .R_V_dest(R_V_dest), .alu_res(alu_res), .store_data(store_data), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_wreg(wb_wreg), .wb_VF(wb_VF),
      .wb_dest(wb_dest), .wb_data(wb_data)
   );

   task automatic apply_idle();
      rmem = 1'b0; wmem = 1'b0; wreg = 1'b0; VF = 1'b0; R_V_dest = 4'd0;
      alu_res = 128'b0; store_data = 128'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      apply_idle();
      repeat (3) @(posedge clk);
      #1;
      rmem = 1'b1;
      @(negedge clk);
      total++;
      if ({stall, mem_req} !== 2'b00) $display("FAIL reset_stall: got %b expected 00", {stall, mem_req});
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if ({wb_wreg, wb_VF, wb_dest, wb_data} !== 134'b0)
         $display("FAIL reset_wb: got %h expected 0", {wb_wreg, wb_VF, wb_dest, wb_data});
      else passed++;
      rst = 1'b0;
      apply_idle();
      m_vf = 1'b0; m_dest = 4'd0; m_data = 128'b0;
      $display("txn reset");
   endtask

   task automatic non_mem_op(input logic wr, input logic vf, input logic [3:0] dest,
                             input logic [127:0] alu, input logic ack_noise, input string name);
      rmem = 1'b0; wmem = 1'b0; wreg = wr; VF = vf; R_V_dest = dest; alu_res = alu;
      store_data = rand128(); mem_ack = ack_noise; mem_rdata = $urandom;
      @(negedge clk);
      total++;
      if ({stall, mem_req, mem_we, mem_addr, mem_wdata} !== 67'b0)
         $display("FAIL %s_port: got %h expected 0", name, {stall, mem_req, mem_we, mem_addr, mem_wdata});
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if ({wb_wreg, wb_VF, wb_dest, wb_data} !== {wr, vf, dest, alu})
         $display("FAIL %s_wb: got %h expected %h", name, {wb_wreg, wb_VF, wb_dest, wb_data},
                  {wr, vf, dest, alu});
      else passed++;
      m_vf = vf; m_dest = dest; m_data = alu;
      apply_idle();
      $display("txn %s: non-mem wreg=%0b vf=%0b dest=%0d data=%h", name, wr, vf, dest, alu);
   endtask

   // waits < 0 selects random wait states per beat; rdata_seed != 0 gives seed+beat as read data.
   task automatic mem_op(input logic r, input logic w, input logic wr, input logic vf,
                         input logic [3:0] dest, input logic [127:0] alu, input logic [127:0] sd,
                         input int waits, input logic [31:0] rdata_seed, input string name,
                         output int stall_cnt);
      int n = vf ? 4 : 1;
      int exp_stall = 0;
      logic [31:0] base = {alu[31:2], 2'b00};
      logic exp_we = w & ~r;
      logic [31:0] rd [4];
      logic [127:0] exp_data;
      stall_cnt = 0;
      rmem = r; wmem = w; wreg = wr; VF = vf; R_V_dest = dest; alu_res = alu; store_data = sd;
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if ({stall, mem_req} !== 2'b10) $display("FAIL %s_req_cycle: got %b expected 10", name, {stall, mem_req});
      else passed++;
      stall_cnt += int'(stall);
      exp_stall++;
      @(posedge clk);
      #1;
      total++;
      if ({wb_wreg, wb_VF, wb_dest, wb_data} !== {1'b0, m_vf, m_dest, m_data})
         $display("FAIL %s_bubble0: got %h expected %h", name, {wb_wreg, wb_VF, wb_dest, wb_data},
                  {1'b0, m_vf, m_dest, m_data});
      else passed++;
      for (int b = 0; b < n; b++) begin
         int wt = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
         for (int k = 0; k <= wt; k++) begin
            logic ack = (k == wt);
            logic fin = ack && (b == n - 1);
            mem_ack = ack;
            mem_rdata = (rdata_seed != 0) ? rdata_seed + 32'(b) : $urandom;
            if (ack) rd[b] = mem_rdata;
            @(negedge clk);
            total++;
            if ({stall, mem_req, mem_we, mem_addr, mem_wdata} !==
                {~fin, 1'b1, exp_we, base + 32'(4 * b), sd[32*b +: 32]})
               $display("FAIL %s_beat%0d: got %h expected %h", name, b,
                        {stall, mem_req, mem_we, mem_addr, mem_wdata},
                        {~fin, 1'b1, exp_we, base + 32'(4 * b), sd[32*b +: 32]});
            else passed++;
            stall_cnt += int'(stall);
            if (!fin) exp_stall++;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!fin) begin
               total++;
               if ({wb_wreg, wb_VF, wb_dest, wb_data} !== {1'b0, m_vf, m_dest, m_data})
                  $display("FAIL %s_bubble: got %h expected %h", name,
                           {wb_wreg, wb_VF, wb_dest, wb_data}, {1'b0, m_vf, m_dest, m_data});
               else passed++;
            end
         end
      end
      if (exp_we) exp_data = alu;
      else if (vf) exp_data = {rd[3], rd[2], rd[1], rd[0]};
      else exp_data = {96'b0, rd[0]};
      total++;
      if ({wb_wreg, wb_VF, wb_dest, wb_data} !== {wr, vf, dest, exp_data})
         $display("FAIL %s_wb: got %h expected %h", name, {wb_wreg, wb_VF, wb_dest, wb_data},
                  {wr, vf, dest, exp_data});
      else passed++;
      total++;
      if (stall_cnt !== exp_stall) $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, exp_stall);
      else passed++;
      m_vf = vf; m_dest = dest; m_data = exp_data;
      apply_idle();
      $display("txn %s: %s vf=%0b addr=%h dest=%0d wb=%h stalls=%0d", name,
               exp_we ? "store" : "load", vf, base, dest, exp_data, stall_cnt);
   endtask

   task automatic test_non_mem();
      non_mem_op(1'b1, 1'b0, 4'd5, 128'h1234, 1'b0, "nonmem");
      non_mem_op(1'b1, 1'b1, 4'd9, rand128(), 1'b1, "ack_in_idle");
   endtask

   task automatic test_scalar_load();
      int sc;
      mem_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 128'h103, rand128(), 0, 32'hDEADBEEF, "scalar_load", sc);
      total++;
      if ({wb_data, sc} !== {128'hDEADBEEF, 32'd1})
         $display("FAIL scalar_load_fixed: got %h/%0d expected DEADBEEF/1", wb_data, sc);
      else passed++;
   endtask

   task automatic test_vector_store();
      int sc;
      mem_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 128'h200,
             {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1, 32'h0, "vector_store", sc);
      total++;
      if ({wb_wreg, 32'(sc)} !== {1'b0, 32'd8})
         $display("FAIL vector_store_fixed: got wreg=%0b stalls=%0d expected 0/8", wb_wreg, sc);
      else passed++;
   endtask

   task automatic test_vector_load();
      int sc;
      mem_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 128'h3F0, rand128(), -1, 32'hA0000000, "vector_load", sc);
      total++;
      if ({wb_VF, wb_data} !== {1'b1, 32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000})
         $display("FAIL vector_load_fixed: got %h expected {D,C,B,A}", {wb_VF, wb_data});
      else passed++;
   endtask

   task automatic test_both_flags();
      int sc;
      mem_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, rand128(), rand128(), -1, 32'h0, "load_wins", sc);
   endtask

   task automatic test_reset_mid_load();
      rmem = 1'b1; wmem = 1'b0; wreg = 1'b1; VF = 1'b1; R_V_dest = 4'd6;
      alu_res = rand128(); store_data = rand128(); mem_ack = 1'b0;
      @(posedge clk);
      #1;
      for (int b = 0; b < 2; b++) begin
         mem_ack = 1'b1;
         mem_rdata = $urandom;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if ({mem_req, wb_wreg, wb_VF, wb_dest, wb_data} !== 135'b0)
         $display("FAIL rst_mid_state: got %h expected 0", {mem_req, wb_wreg, wb_VF, wb_dest, wb_data});
      else passed++;
      rst = 1'b0;
      apply_idle();
      m_vf = 1'b0; m_dest = 4'd0; m_data = 128'b0;
      $display("txn reset_mid_load");
      non_mem_op(1'b1, 1'b0, 4'd11, rand128(), 1'b0, "after_reset");
   endtask

   task automatic test_random();
      int sc;
      for (int i = 0; i < 24; i++) begin
         int kind = int'($urandom_range(0, 5));
         logic [3:0] d = 4'($urandom);
         logic wr = 1'($urandom);
         case (kind)
            0: non_mem_op(wr, 1'($urandom), d, rand128(), 1'($urandom), "rnd_nonmem");
            1: mem_op(1'b1, 1'b0, wr, 1'b0, d, rand128(), rand128(), -1, 32'h0, "rnd_sload", sc);
            2: mem_op(1'b0, 1'b1, wr, 1'b0, d, rand128(), rand128(), -1, 32'h0, "rnd_sstore", sc);
            3: mem_op(1'b1, 1'b0, wr, 1'b1, d, rand128(), rand128(), -1, 32'h0, "rnd_vload", sc);
            4: mem_op(1'b0, 1'b1, wr, 1'b1, d, rand128(), rand128(), -1, 32'h0, "rnd_vstore", sc);
            default: mem_op(1'b1, 1'b1, wr, 1'($urandom), d, rand128(), rand128(), -1, 32'h0, "rnd_both", sc);
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_non_mem();
      test_scalar_load();
      test_vector_store();
      test_vector_load();
      test_both_flags();
      test_reset_mid_load();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
